// File: rtl/mdu_pipe.sv
// Multicycle multiply/divide unit holding the HI/LO pair, with MTHI/MTLO writes and cancel.
// Multiply/divide results land MULT_CYCLES/DIV_CYCLES edges after the accepting edge.
module mdu_pipe #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  logic             w_accept;
  logic             w_finish;
  logic             w_abort;
  logic             w_is_muldiv;
  logic             w_idle_go;
  logic [CW-1:0]    w_latency;

  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic [WIDTH-1:0]   w_q_s;
  logic [WIDTH-1:0]   w_r_s;
  logic [WIDTH-1:0]   w_q_u;
  logic [WIDTH-1:0]   w_r_u;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_is_muldiv = (op == OP_MULT) || (op == OP_MULTU) ||
                       (op == OP_DIV)  || (op == OP_DIVU);
  assign w_idle_go   = (r_state == S_IDLE) && start && !cancel;
  assign w_latency   = ((op == OP_MULT) || (op == OP_MULTU)) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_idle_go && w_is_muldiv) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // cancel wins even on the final counting cycle
        if (cancel) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CW'(1)) begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Results are computed from the latched operands; the counter only paces the write.
  assign w_prod_s = $signed({{WIDTH{r_a[WIDTH-1]}}, r_a}) * $signed({{WIDTH{r_b[WIDTH-1]}}, r_b});
  assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
  assign w_q_s    = $signed(r_a) / $signed(r_b);
  assign w_r_s    = $signed(r_a) % $signed(r_b);
  assign w_q_u    = r_a / r_b;
  assign w_r_u    = r_a % r_b;

  always_comb begin
    w_res_hi = '0;
    w_res_lo = '0;
    case (r_op)
      OP_MULT: begin
        w_res_hi = w_prod_s[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod_s[WIDTH-1:0];
      end
      OP_MULTU: begin
        w_res_hi = w_prod_u[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod_u[WIDTH-1:0];
      end
      OP_DIV: begin
        if (r_b == '0) begin
          w_res_hi = r_a;
          w_res_lo = '1;
        end else if ((r_a == MIN_NEG) && (r_b == '1)) begin
          w_res_hi = '0;
          w_res_lo = MIN_NEG;
        end else begin
          w_res_hi = w_r_s;
          w_res_lo = w_q_s;
        end
      end
      OP_DIVU: begin
        if (r_b == '0) begin
          w_res_hi = r_a;
          w_res_lo = '1;
        end else begin
          w_res_hi = w_r_u;
          w_res_lo = w_q_u;
        end
      end
      default: begin
        w_res_hi = '0;
        w_res_lo = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= w_finish;
      if (w_accept) begin
        r_cnt <= w_latency;
        r_op  <= op;
        r_a   <= a;
        r_b   <= b;
        busy  <= 1'b1;
      end else if (w_finish || w_abort) begin
        r_cnt <= '0;
        busy  <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_finish) begin
        hi <= w_res_hi;
        lo <= w_res_lo;
      end else if (w_idle_go && (op == OP_MTHI)) begin
        hi <= a;
      end else if (w_idle_go && (op == OP_MTLO)) begin
        lo <= a;
      end
    end
  end

endmodule

// File: tb/tb_mdu_pipe.sv
// Randomized and directed bench for mdu_pipe against a per-cycle transaction model
// that computes results with plain 64-bit integer arithmetic.
module tb_mdu_pipe;

  localparam logic [2:0] NONE = 3'd0, MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3,
                         DIVU = 3'd4, MTHI = 3'd5, MTLO = 3'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic        cancel;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [31:0] m_hi, m_lo, m_a, m_b;
  logic [2:0]  m_op;
  int          m_rem;
  logic        m_done;

  mdu_pipe #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .cancel(cancel),
    .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] rh, output logic [31:0] rl);
    longint sx, sy, q, r, p;
    longint unsigned ux, uy, pu;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    rh = '0;
    rl = '0;
    case (o)
      MULT:  begin p = sx * sy; rh = p[63:32]; rl = p[31:0]; end
      MULTU: begin pu = ux * uy; rh = pu[63:32]; rl = pu[31:0]; end
      DIV: begin
        if (y == 32'd0) begin rh = x; rl = 32'hFFFF_FFFF; end
        else begin q = sx / sy; r = sx - q * sy; rh = r[31:0]; rl = q[31:0]; end
      end
      DIVU: begin
        if (y == 32'd0) begin rh = x; rl = 32'hFFFF_FFFF; end
        else begin pu = ux / uy; rh = 32'(ux - pu * uy); rl = pu[31:0]; end
      end
      default: ;
    endcase
  endfunction

  task automatic model_reset();
    m_hi = '0; m_lo = '0; m_rem = 0; m_done = 1'b0;
    m_op = NONE; m_a = '0; m_b = '0;
  endtask

  task automatic model_edge();
    logic [31:0] rh, rl;
    m_done = 1'b0;
    if (m_rem > 0) begin
      if (cancel) m_rem = 0;
      else if (m_rem == 1) begin
        ref_result(m_op, m_a, m_b, rh, rl);
        m_hi = rh; m_lo = rl; m_done = 1'b1; m_rem = 0;
      end else m_rem--;
    end else if (start && !cancel) begin
      case (op)
        MULT, MULTU: begin m_rem = 5;  m_op = op; m_a = a; m_b = b; end
        DIV, DIVU:   begin m_rem = 10; m_op = op; m_a = a; m_b = b; end
        MTHI: m_hi = a;
        MTLO: m_lo = a;
        default: ;
      endcase
    end
  endtask

  task automatic do_cycle(input logic st, input logic [2:0] o, input logic cn,
                          input logic [31:0] aa, input logic [31:0] bb);
    start = st; op = o; cancel = cn; a = aa; b = bb;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("busy", busy, m_rem > 0);
    chk("done", done, m_done);
  endtask

  task automatic idle_cycle();
    do_cycle(1'b0, NONE, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] aa,
                        input logic [31:0] bb, input int lat,
                        input logic [31:0] eh, input logic [31:0] el);
    int nb, nd;
    nb = 0; nd = 0;
    do_cycle(1'b1, o, 1'b0, aa, bb);
    if (busy) nb++;
    for (int i = 0; i < lat + 2; i++) begin
      idle_cycle();
      if (busy) nb++;
      if (done) nd++;
    end
    chk({tag, "_busy_cycles"}, nb, lat);
    chk({tag, "_done_pulses"}, nd, 1);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
  endtask

  task automatic async_reset();
    #1 reset = 1'b1;
    #1;
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    model_reset();
    #1 reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nd, guard;
    reset = 1'b1; start = 1'b0; op = NONE; cancel = 1'b0; a = '0; b = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;

    run_op("mult_neg",   MULT,  32'hFFFF_FFFD, 32'd5,         5,  32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu",      MULTU, 32'hFFFF_FFFF, 32'd2,         5,  32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div_neg",    DIV,   32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",       DIVU,  32'd7,         32'd2,         10, 32'd1,         32'd3);
    run_op("div_ovf",    DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0,         32'h8000_0000);
    run_op("divu_zero",  DIVU,  32'd5,         32'd0,         10, 32'd5,         32'hFFFF_FFFF);

    // starts during RUN are ignored
    do_cycle(1'b1, MULT, 1'b0, 32'd2, 32'd3);
    idle_cycle();
    do_cycle(1'b1, MTHI, 1'b0, 32'hAAAA_5555, 32'd0);
    do_cycle(1'b1, DIV,  1'b0, 32'd100, 32'd7);
    nd = 0; guard = 0;
    while (!done && guard < 20) begin idle_cycle(); guard++; end
    chk("hazard_done_seen", done, 1);
    chk("hazard_hi", hi, 32'd0);
    chk("hazard_lo", lo, 32'd6);
    do_cycle(1'b1, MTLO, 1'b0, 32'h1234_5678, 32'd0);
    chk("mtlo_lo", lo, 32'h1234_5678);
    chk("mtlo_busy", busy, 0);

    // cancel mid-divide
    do_cycle(1'b1, MTHI, 1'b0, 32'd1, 32'd0);
    do_cycle(1'b1, MTLO, 1'b0, 32'd2, 32'd0);
    do_cycle(1'b1, DIV, 1'b0, 32'd50, 32'd3);
    repeat (3) idle_cycle();
    do_cycle(1'b0, NONE, 1'b1, 32'd0, 32'd0);
    chk("cancel_busy", busy, 0);
    for (int i = 0; i < 12; i++) begin
      idle_cycle();
      if (done) nd++;
    end
    chk("cancel_no_done", nd, 0);
    chk("cancel_hi", hi, 32'd1);
    chk("cancel_lo", lo, 32'd2);

    // cancel in IDLE blocks MTHI
    do_cycle(1'b1, MTHI, 1'b1, 32'hDEAD_BEEF, 32'd0);
    chk("idle_cancel_hi", hi, 32'd1);

    // asynchronous reset mid-multiply
    do_cycle(1'b1, MULT, 1'b0, 32'd9, 32'd9);
    idle_cycle();
    async_reset();
    idle_cycle();
    run_op("post_rst", MULTU, 32'd4, 32'd4, 5, 32'd0, 32'd16);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      logic st, cn;
      st = ($urandom_range(0, 2) == 0);
      cn = ($urandom_range(0, 29) == 0);
      do_cycle(st, 3'($urandom_range(0, 7)), cn, rand_operand(), rand_operand());
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_pipe.md
MDU_PIPE -- requirements
Module: mdu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width in bits.
REQ-002 The block SHALL have parameter MULT_CYCLES, default 5, giving the multiply latency in cycles; legal values are 1 or more.
REQ-003 The block SHALL have parameter DIV_CYCLES, default 10, giving the divide latency in cycles; legal values are 1 or more.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port start, input, 1 bit: requests the operation given by op in this cycle.
REQ-007 Port op, input, 3 bits, encoded as follows:
- 000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO
- 111 reserved, treated as NONE.
REQ-008 Port cancel, input, 1 bit: aborts an in-flight multiply or divide (exception flush).
REQ-009 Port a, input, WIDTH bits: operand A (dividend; or source value for MTHI/MTLO).
REQ-010 Port b, input, WIDTH bits: operand B (divisor).
REQ-011 Port hi, output, WIDTH bits: the registered HI value.
REQ-012 Port lo, output, WIDTH bits: the registered LO value.
REQ-013 Port busy, output, 1 bit: registered; high while a multiply or divide is in flight.
REQ-014 Port done, output, 1 bit: registered; a one-cycle pulse in the cycle HI/LO first show a new multiply or divide result.

Function
REQ-015 There SHALL be two states, IDLE and RUN, plus a down-counter sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-016 IDLE with start=1, cancel=0 and op MULT/MULTU/DIV/DIVU: on that edge, latch a, b and op; load the counter with the latency; go to RUN.
- busy is high from the next cycle for exactly the latency in cycles.
REQ-017 IDLE with start=1, cancel=0 and op MTHI (MTLO): write a into hi (lo) at that edge; busy stays 0; done stays 0.
REQ-018 RUN: decrement the counter every cycle; when it reaches zero, at that edge write the result into HI/LO, set done=1, set busy=0 and return to IDLE.
- Net timing: a start at edge k gives the result visible after edge k+N, where N is the latency.
REQ-019 MULT SHALL form the signed 2·WIDTH product and MULTU the unsigned one; hi gets the upper half, lo the lower half.
REQ-020 DIV/DIVU SHALL put the quotient in lo and the remainder in hi.
- Signed division truncates toward zero.
- The remainder takes the sign of the dividend.
REQ-021 Divide by zero (b=0), signed or unsigned, SHALL give hi=a and lo={WIDTH{1}}, with normal latency and no error flag.
REQ-022 Signed overflow (most-negative / -1) SHALL give lo=most-negative and hi=0.
REQ-023 While in RUN, start SHALL be ignored for every op, including MTHI/MTLO; the pipeline hazard unit SHALL stall on (start & muldiv op) | busy.
REQ-024 cancel=1 while in RUN SHALL abort at that edge: return to IDLE, busy=0, done=0, HI/LO unchanged.
REQ-025 cancel=1 in IDLE SHALL block any start in the same cycle, including MTHI/MTLO.
REQ-026 In the cycle the counter reaches zero, the edge completes the operation and goes to IDLE.
- A start in that same cycle is ignored, because the block is still in RUN at the sampling edge.
- The next start is accepted one cycle later.
REQ-027 done SHALL be 0 in every cycle except the single pulse of REQ-018.
REQ-028 The hi/lo outputs SHALL hold their previous values throughout RUN.
- There is no early forwarding of partial results.

Reset
REQ-029 reset=1 SHALL immediately, without waiting for a clock edge, force hi=0, lo=0, busy=0, done=0, state=IDLE and counter=0.
REQ-030 A reset asserted during RUN SHALL discard the in-flight operation entirely.
- After release, the first edge with start=1 is accepted normally.

Verification
REQ-031 Run all cases below with WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10.
REQ-032 MULT a=FFFFFFFD (-3), b=5 -> busy high 5 cycles, then hi=FFFFFFFF, lo=FFFFFFF1, done pulses once.
- MULTU a=FFFFFFFF, b=2 -> hi=00000001, lo=FFFFFFFE.
REQ-033 DIV a=FFFFFFF9 (-7), b=2 -> after 10 busy cycles lo=FFFFFFFD, hi=FFFFFFFF.
- DIVU a=7, b=2 -> lo=3, hi=1.
- DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
REQ-034 DIVU a=5, b=0 -> hi=00000005, lo=FFFFFFFF after 10 cycles.
REQ-035 MULT 2×3 in flight, then MTHI a=AAAA5555 at cycle 2 and DIV start at cycle 3 -> both ignored.
- Final state hi=0, lo=6.
- An MTLO one cycle after done writes lo immediately, with busy staying 0.
REQ-036 DIV in flight with hi=1, lo=2, then cancel at cycle 4 -> busy=0 next cycle, hi=1, lo=2 unchanged, no done.
- Reset asserted mid-MULT between clock edges -> hi=lo=0 and busy=0 immediately.
